interp_line_feeder: RTL and testbench

Streams one 16x16 block of 32-bit samples, row by row or column by column, into the 6-tap half-sample `interpolator` as an edge-replicated pixel stream. It also captures the interpolator's three tap outputs (a/b/c, bits [37:6]) into a result memory at the matching pixel index. It sits directly upstream of `interpolator`, driving its `data_in`, and directly downstream of it, consuming `aValue/bValue/cValue`. It replaces the hand-written ABC/DHN/EIP/FJQ/GKR feed loops with one reusable hardware sequencer.

---
 rtl/interp_line_feeder.sv | 131 +++++++++++++
 tb/tb_interp_line_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/interp_line_feeder.sv
// Sequencer that feeds one 16x16 block, line by line, into the 6-tap half-sample
// interpolator with edge replication, and captures its a/b/c taps into a result memory.
module interp_line_feeder #(
  parameter int DATA_W   = 32,
  parameter int TAP_W    = 40,
  parameter int PAD_PRE  = 8,
  parameter int PAD_POST = 5,
  parameter int CAP_LAG  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  input  logic [TAP_W-1:0]  tap_a,
  input  logic [TAP_W-1:0]  tap_b,
  input  logic [TAP_W-1:0]  tap_c,
  output logic              wr_en,
  output logic [7:0]        wr_addr,
  output logic [DATA_W-1:0] wr_a,
  output logic [DATA_W-1:0] wr_b,
  output logic [DATA_W-1:0] wr_c
);

  localparam int LINE_LEN  = PAD_PRE + 16 + PAD_POST;
  localparam int CAP_FIRST = PAD_PRE + CAP_LAG;
  // One spare code so the look-ahead index s+1 never wraps.
  localparam int S_W       = $clog2(LINE_LEN + 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} stateT;

  stateT          state, nextState;
  logic           modeLat;
  logic [3:0]     lineIdx;
  logic [S_W-1:0] sIdx;
  logic [7:0]     holdAddr;
  logic [7:0]     rdAddrCur;
  logic           lastCyc, lastLine, capHit;
  logic [3:0]     capIdx;

  function automatic logic [3:0] elemOf(input logic [S_W-1:0] s);
    if (int'(s) < PAD_PRE)             return 4'd0;
    else if (int'(s) >= PAD_PRE + 15)  return 4'd15;
    else                               return 4'(int'(s) - PAD_PRE);
  endfunction

  // Row mode walks r*16+c along a row; column mode swaps the nibbles.
  function automatic logic [7:0] blkAddr(input logic colMode, input logic [3:0] line,
                                         input logic [3:0] elem);
    return colMode ? {elem, line} : {line, elem};
  endfunction

  assign lastCyc  = (sIdx == S_W'(LINE_LEN - 1));
  assign lastLine = (lineIdx == 4'd15);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = PRIME;
      PRIME:   nextState = STREAM;
      STREAM:  if (lastCyc && lastLine) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state    <= IDLE;
      modeLat  <= 1'b0;
      lineIdx  <= 4'd0;
      sIdx     <= '0;
      holdAddr <= 8'd0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) begin
        modeLat <= mode;
        lineIdx <= 4'd0;
        sIdx    <= '0;
      end
      if (state == STREAM) begin
        if (lastCyc) begin
          sIdx    <= '0;
          lineIdx <= lineIdx + 4'd1;
        end else begin
          sIdx <= sIdx + S_W'(1);
        end
      end
      if (busy) holdAddr <= rdAddrCur;
    end
  end

  // The read address always runs one stream cycle ahead of pix_out.
  always_comb begin
    rdAddrCur = 8'd0;
    if (state == PRIME) begin
      rdAddrCur = blkAddr(modeLat, 4'd0, 4'd0);
    end else if (state == STREAM) begin
      if (lastCyc && !lastLine) rdAddrCur = blkAddr(modeLat, lineIdx + 4'd1, 4'd0);
      else                      rdAddrCur = blkAddr(modeLat, lineIdx, elemOf(sIdx + S_W'(1)));
    end
  end

  assign busy      = (state == PRIME) || (state == STREAM);
  assign done      = (state == DONE);
  assign pix_valid = (state == STREAM);
  assign rd_addr   = busy ? rdAddrCur : holdAddr;
  assign pix_out   = pix_valid ? rd_data : '0;

  assign capHit  = (state == STREAM) && (int'(sIdx) >= CAP_FIRST) && (int'(sIdx) <= CAP_FIRST + 15);
  assign capIdx  = 4'(int'(sIdx) - CAP_FIRST);
  assign wr_en   = capHit;
  assign wr_addr = capHit ? blkAddr(modeLat, lineIdx, capIdx) : 8'd0;
  assign wr_a    = capHit ? tap_a[DATA_W+5:6] : '0;
  assign wr_b    = capHit ? tap_b[DATA_W+5:6] : '0;
  assign wr_c    = capHit ? tap_c[DATA_W+5:6] : '0;

  // Tap guard and fraction bits are dropped by design (plain truncation).
  logic unusedTapBits;
  assign unusedTapBits = ^{tap_a[TAP_W-1:DATA_W+6], tap_a[5:0],
                           tap_b[TAP_W-1:DATA_W+6], tap_b[5:0],
                           tap_c[TAP_W-1:DATA_W+6], tap_c[5:0]};

endmodule

// File: tb/tb_interp_line_feeder.sv
// Directed bench for interp_line_feeder: vector table for one row pass plus
// hand-written sequences for column order, restart, reset abort and mode latching.
module tb_interp_line_feeder;

  localparam int DATA_W = 32;
  localparam int TAP_W  = 40;
  localparam int NREC   = 1000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode  = 1'b0;
  logic              busy, done, pix_valid, wr_en;
  logic [7:0]        rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data, pix_out, wr_a, wr_b, wr_c;
  logic [TAP_W-1:0]  tap_a, tap_b, tap_c;

  interp_line_feeder dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_out(pix_out), .pix_valid(pix_valid),
    .tap_a(tap_a), .tap_b(tap_b), .tap_c(tap_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b), .wr_c(wr_c)
  );

  always #5 clock = ~clock;

  // Source block (source[a] = a) with synchronous read.
  logic [DATA_W-1:0] src [0:255];
  always @(posedge clock) rd_data <= src[rd_addr];

  // Interpolator stand-in: taps echo the pixel streamed five cycles earlier.
  logic [DATA_W-1:0] pipe [0:4];
  always @(posedge clock) begin
    pipe[0] <= pix_out;
    for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
  end
  assign tap_a = {2'b00, pipe[4], 6'd0};
  assign tap_b = 40'h00_0000_01FF;
  assign tap_c = {2'b11, pipe[4] ^ 32'hFFFF_0000, 6'h3F};

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int clampE(input int s);
    if (s < 8)  return 0;
    if (s > 23) return 15;
    return s - 8;
  endfunction

  logic              recBusy [0:NREC-1];
  logic              recDone [0:NREC-1];
  logic              recPv   [0:NREC-1];
  logic              recWe   [0:NREC-1];
  logic [7:0]        recRd   [0:NREC-1];
  logic [7:0]        recWa   [0:NREC-1];
  logic [DATA_W-1:0] recPix  [0:NREC-1];
  logic [DATA_W-1:0] recA    [0:NREC-1];
  logic [DATA_W-1:0] recB    [0:NREC-1];
  logic [DATA_W-1:0] recC    [0:NREC-1];

  // Cycle k=0 drives start; the edge ending k=0 is E0, so PRIME is k=1.
  task automatic runPass(input logic m, input int nCyc, input int extraStart1,
                         input int extraStart2, input int flipK, input logic flipVal,
                         input int resetK);
    for (int k = 0; k < nCyc; k++) begin
      start = (k == 0) || (k == extraStart1) || (k == extraStart2);
      if (k == 0) mode = m;
      if (k == flipK) mode = flipVal;
      reset = (k == resetK);
      recBusy[k] = busy;    recDone[k] = done;  recPv[k] = pix_valid; recWe[k] = wr_en;
      recRd[k]   = rd_addr; recWa[k]   = wr_addr; recPix[k] = pix_out;
      recA[k]    = wr_a;    recB[k]    = wr_b;  recC[k] = wr_c;
      @(posedge clock); #1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic checkWrites(input int kBase, input logic m, input string tag);
    int n = 0;
    logic [7:0] expAddr;
    for (int k = kBase + 1; k <= kBase + 466; k++) begin
      if (recWe[k]) begin
        expAddr = m ? {n[3:0], n[7:4]} : n[7:0];
        if (n < 256) begin
          check($sformatf("%s write %0d wr_addr", tag, n), 32'(recWa[k]), 32'(expAddr));
          check($sformatf("%s write %0d wr_a", tag, n), recA[k], 32'(expAddr));
          check($sformatf("%s write %0d wr_b", tag, n), recB[k], 32'd7);
          check($sformatf("%s write %0d wr_c", tag, n), recC[k], 32'(expAddr) ^ 32'hFFFF_0000);
        end
        n++;
      end else begin
        check($sformatf("%s k%0d idle wr_b", tag, k - kBase), recB[k], 32'd0);
        check($sformatf("%s k%0d idle wr_a", tag, k - kBase), recA[k], 32'd0);
      end
    end
    check($sformatf("%s write count", tag), 32'(n), 32'd256);
  endtask

  task automatic checkDone(input int kFrom, input int kTo, input int expCnt,
                           input int expAt, input string tag);
    int cnt = 0;
    int at  = -1;
    for (int k = kFrom; k <= kTo; k++) if (recDone[k]) begin
      cnt++;
      if (at < 0) at = k;
    end
    check($sformatf("%s done count", tag), 32'(cnt), 32'(expCnt));
    if (expCnt > 0) check($sformatf("%s done cycle", tag), 32'(at), 32'(expAt));
  endtask

  typedef struct {
    int         k;
    logic       busy, pv, done, we, rdCare;
    logic [7:0] rd, wa;
    logic [31:0] pix;
  } vecT;

  vecT rowVec [13];

  initial begin
    rowVec[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,   32'd0};
    rowVec[1]  = '{1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,   32'd0};
    rowVec[2]  = '{2,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,   32'd0};
    rowVec[3]  = '{10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1,  8'd0,   32'd0};
    rowVec[4]  = '{11,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2,  8'd0,   32'd1};
    rowVec[5]  = '{15,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd6,  8'd0,   32'd5};
    rowVec[6]  = '{30,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd16, 8'd15,  32'd15};
    rowVec[7]  = '{31,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd16, 8'd0,   32'd16};
    rowVec[8]  = '{102, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd54, 8'd48,  32'd53};
    rowVec[9]  = '{103, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd55, 8'd49,  32'd54};
    rowVec[10] = '{465, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  8'd255, 32'd255};
    rowVec[11] = '{466, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'd0,   32'd0};
    rowVec[12] = '{467, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,   32'd0};

    for (int a = 0; a < 256; a++) src[a] = 32'(a);

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset pix_valid", 32'(pix_valid), 32'd0);
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset rd_addr", 32'(rd_addr), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset pix_out", pix_out, 32'd0);
    check("reset wr_abc", wr_a | wr_b | wr_c, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Row pass; start re-pulsed at stream cycle 100 and in DONE; mode flipped mid-pass.
    runPass(1'b0, 471, 102, 466, 150, 1'b1, -1);
    foreach (rowVec[i]) begin
      check($sformatf("row k%0d busy", rowVec[i].k), 32'(recBusy[rowVec[i].k]), 32'(rowVec[i].busy));
      check($sformatf("row k%0d pix_valid", rowVec[i].k), 32'(recPv[rowVec[i].k]), 32'(rowVec[i].pv));
      check($sformatf("row k%0d done", rowVec[i].k), 32'(recDone[rowVec[i].k]), 32'(rowVec[i].done));
      check($sformatf("row k%0d wr_en", rowVec[i].k), 32'(recWe[rowVec[i].k]), 32'(rowVec[i].we));
      check($sformatf("row k%0d wr_addr", rowVec[i].k), 32'(recWa[rowVec[i].k]), 32'(rowVec[i].wa));
      check($sformatf("row k%0d pix_out", rowVec[i].k), recPix[rowVec[i].k], rowVec[i].pix);
      if (rowVec[i].rdCare)
        check($sformatf("row k%0d rd_addr", rowVec[i].k), 32'(recRd[rowVec[i].k]), 32'(rowVec[i].rd));
    end
    for (int s = 0; s < 29; s++)
      check($sformatf("row line1 s%0d pix_out", s), recPix[31 + s], 32'(16 + clampE(s)));
    checkWrites(0, 1'b0, "row");
    checkDone(0, 470, 1, 466, "row");
    for (int k = 467; k <= 470; k++) check($sformatf("row k%0d no restart", k), 32'(recBusy[k]), 32'd0);

    // Column pass, mode flipped mid-pass, then start the cycle after DONE chains a row pass.
    runPass(1'b1, 940, 467, -1, 150, 1'b0, -1);
    for (int k = 1; k <= 30; k++) begin
      int exp;
      if (k == 1)       exp = 0;
      else if (k == 30) exp = 1;
      else              exp = clampE(k - 1) * 16;
      check($sformatf("col line0 k%0d rd_addr", k), 32'(recRd[k]), 32'(exp));
    end
    checkWrites(0, 1'b1, "col");
    check("chain idle after done", 32'(recBusy[467]), 32'd0);
    check("chain prime busy", 32'(recBusy[468]), 32'd1);
    check("chain prime pix_valid", 32'(recPv[468]), 32'd0);
    check("chain first pix_valid", 32'(recPv[469]), 32'd1);
    checkWrites(467, 1'b0, "chain");
    checkDone(0, 466, 1, 466, "col");
    checkDone(467, 939, 1, 933, "chain");

    // Reset at stream cycle 200 abandons the pass.
    runPass(1'b0, 480, -1, -1, -1, 1'b0, 202);
    check("abort busy before reset", 32'(recBusy[202]), 32'd1);
    check("abort busy", 32'(recBusy[203]), 32'd0);
    check("abort done", 32'(recDone[203]), 32'd0);
    check("abort pix_valid", 32'(recPv[203]), 32'd0);
    check("abort wr_en", 32'(recWe[203]), 32'd0);
    check("abort rd_addr", 32'(recRd[203]), 32'd0);
    check("abort wr_addr", 32'(recWa[203]), 32'd0);
    check("abort pix_out", recPix[203], 32'd0);
    check("abort wr_abc", recA[203] | recB[203] | recC[203], 32'd0);
    checkDone(0, 479, 0, 0, "abort");
    begin
      int late = 0;
      for (int k = 203; k < 480; k++) if (recBusy[k] || recWe[k]) late++;
      check("abort stays idle", 32'(late), 32'd0);
    end

    // Fresh pass after the abort.
    runPass(1'b0, 470, -1, -1, -1, 1'b0, -1);
    checkWrites(0, 1'b0, "fresh");
    checkDone(0, 469, 1, 466, "fresh");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
